// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encodings, default sizes
// and an index-width helper usable in parameter expressions.
package arb_pkg;

    localparam int ARB_N_DEF        = 4;
    localparam int ARB_MAX_HOLD_DEF = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Clamped to 1 so a degenerate N never produces a zero-width index.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_enc_rr.sv
// Circular priority encoder: the first set req bit found scanning from ptr
// upward, wrapping modulo N. Purely combinational.
module prio_enc_rr
    import arb_pkg::*;
#(
    parameter int N    = ARB_N_DEF,
    parameter int IDXW = idx_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDXW-1:0] off;
    logic [IDXW:0]   sum;

    // Duplicating req lets a plain right shift act as a rotate for any N.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
    end

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IDXW'(i);
        end
    end

    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDXW+1)'(N)) sum = sum - (IDXW+1)'(N);
        idx = sum[IDXW-1:0];
        any = |req;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter with grant hold: one owner at a time, released on done,
// on request drop, or forcibly after MAX_HOLD cycles.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int IDXW     = idx_width(N),
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            busy,
    output logic            timeout
);

    arb_state_t      state, state_nxt;
    logic [IDXW-1:0] ptr, ptr_nxt;
    logic [CW-1:0]   hold_cnt, cnt_nxt;
    logic [N-1:0]    grant_nxt;
    logic [IDXW-1:0] idx_nxt;
    logic            busy_nxt, timeout_nxt;

    logic [IDXW-1:0] win_idx;
    logic            win_any;
    logic            rel_norm, rel_max, release_now;
    logic [IDXW:0]   ptr_inc;

    prio_enc_rr #(.N(N), .IDXW(IDXW)) u_enc (
        .req (req),
        .ptr (ptr),
        .idx (win_idx),
        .any (win_any)
    );

    // A normal release (done or request drop) masks the timeout pulse.
    always_comb begin
        rel_norm    = done | ~req[grant_idx];
        rel_max     = (hold_cnt == CW'(MAX_HOLD));
        release_now = (state == ST_GRANT) & (rel_norm | rel_max);
        ptr_inc     = {1'b0, grant_idx} + (IDXW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= cnt_nxt;
            grant     <= grant_nxt;
            grant_idx <= idx_nxt;
            busy      <= busy_nxt;
            timeout   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en && win_any) state_nxt = ST_GRANT;
            ST_GRANT: if (release_now)   state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_nxt     = ptr;
        cnt_nxt     = hold_cnt;
        grant_nxt   = grant;
        idx_nxt     = grant_idx;
        busy_nxt    = busy;
        timeout_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && win_any) begin
                    grant_nxt = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    idx_nxt   = win_idx;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = CW'(1);
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    grant_nxt   = '0;
                    idx_nxt     = '0;
                    busy_nxt    = 1'b0;
                    cnt_nxt     = '0;
                    ptr_nxt     = (ptr_inc == (IDXW+1)'(N)) ? '0 : ptr_inc[IDXW-1:0];
                    timeout_nxt = rel_max & ~rel_norm;
                end else begin
                    cnt_nxt = hold_cnt + CW'(1);
                end
            end
            default: begin
                grant_nxt = '0;
                idx_nxt   = '0;
                busy_nxt  = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
